// File: rtl/bwd_mem_req_sched.sv
// Serialises k/l cache-line reads from the backward-extension stage onto one memory port,
// merging duplicate lines and throttling on an outstanding-read credit count.
module bwd_mem_req_sched #(
  parameter int unsigned ADDR_W          = 42,
  parameter int unsigned TAG_W           = 6,
  parameter int unsigned MAX_OUTSTANDING = 16,
  parameter int unsigned CNT_W           = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic [TAG_W-1:0]    req_read_num,
  input  logic [ADDR_W-1:0]   req_addr_k,
  input  logic [ADDR_W-1:0]   req_addr_l,
  output logic                stall,
  output logic                mem_req_valid,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [TAG_W+1:0]    mem_req_tag,
  input  logic                mem_req_ready,
  input  logic                mem_rsp_valid,
  output logic [CNT_W-1:0]    outstanding,
  output logic                err_underflow
);

  localparam int unsigned MTAG_W = TAG_W + 2;
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE_K = 2'd1;
  localparam logic [1:0] S_ISSUE_L = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [TAG_W-1:0]  r_rn;
  logic [ADDR_W-1:0] r_addr_k;
  logic [ADDR_W-1:0] r_addr_l;
  logic              r_dup;
  logic              r_mem_req_valid;
  logic [ADDR_W-1:0] r_mem_req_addr;
  logic [MTAG_W-1:0] r_mem_req_tag;
  logic [CNT_W-1:0]  r_outstanding;
  logic              r_err;

  logic              w_accept;
  logic              w_hs;
  logic              w_dup_in;
  logic              w_valid_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [MTAG_W-1:0] w_tag_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_err_nxt;

  // Two credits are reserved so an accepted non-dup pair can always issue both reads.
  assign stall    = (r_state != S_IDLE) |
                    (r_outstanding > CNT_W'(MAX_OUTSTANDING - 2));
  assign w_accept = req_valid & ~stall;
  assign w_hs     = r_mem_req_valid & mem_req_ready;
  assign w_dup_in = (req_addr_k == req_addr_l);

  assign mem_req_valid = r_mem_req_valid;
  assign mem_req_addr  = r_mem_req_addr;
  assign mem_req_tag   = r_mem_req_tag;
  assign outstanding   = r_outstanding;
  assign err_underflow = r_err;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next state plus the next contents of the registered memory port.
  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = 1'b0;
    w_addr_nxt  = '0;
    w_tag_nxt   = '0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_ISSUE_K;
          w_valid_nxt = 1'b1;
          w_addr_nxt  = req_addr_k;
          w_tag_nxt   = {req_read_num, 1'b0, w_dup_in};
        end
      end
      S_ISSUE_K: begin
        if (mem_req_ready) begin
          if (r_dup) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_ISSUE_L;
            w_valid_nxt = 1'b1;
            w_addr_nxt  = r_addr_l;
            w_tag_nxt   = {r_rn, 1'b1, 1'b0};
          end
        end else begin
          w_valid_nxt = 1'b1;
          w_addr_nxt  = r_addr_k;
          w_tag_nxt   = {r_rn, 1'b0, r_dup};
        end
      end
      S_ISSUE_L: begin
        if (mem_req_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_valid_nxt = 1'b1;
          w_addr_nxt  = r_addr_l;
          w_tag_nxt   = {r_rn, 1'b1, 1'b0};
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Credit counter: a response with nothing in flight and no same-cycle issue is an error.
  always_comb begin
    w_cnt_nxt = r_outstanding;
    w_err_nxt = r_err;
    if (w_hs && !mem_rsp_valid) begin
      w_cnt_nxt = r_outstanding + CNT_W'(1);
    end else if (!w_hs && mem_rsp_valid) begin
      if (r_outstanding == '0) w_err_nxt = 1'b1;
      else                     w_cnt_nxt = r_outstanding - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rn            <= '0;
      r_addr_k        <= '0;
      r_addr_l        <= '0;
      r_dup           <= 1'b0;
      r_mem_req_valid <= 1'b0;
      r_mem_req_addr  <= '0;
      r_mem_req_tag   <= '0;
      r_outstanding   <= '0;
      r_err           <= 1'b0;
    end else begin
      if (w_accept) begin
        r_rn     <= req_read_num;
        r_addr_k <= req_addr_k;
        r_addr_l <= req_addr_l;
        r_dup    <= w_dup_in;
      end
      r_mem_req_valid <= w_valid_nxt;
      r_mem_req_addr  <= w_addr_nxt;
      r_mem_req_tag   <= w_tag_nxt;
      r_outstanding   <= w_cnt_nxt;
      r_err           <= w_err_nxt;
    end
  end

endmodule

// File: tb/tb_bwd_mem_req_sched.sv
// Directed bench for bwd_mem_req_sched: hand-computed port, stall and credit expectations.
module tb_bwd_mem_req_sched;

  localparam int unsigned ADDR_W = 42;
  localparam int unsigned TAG_W  = 6;
  localparam int unsigned CNT_W  = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic [TAG_W-1:0]  req_read_num;
  logic [ADDR_W-1:0] req_addr_k;
  logic [ADDR_W-1:0] req_addr_l;
  logic              stall;
  logic              mem_req_valid;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [TAG_W+1:0]  mem_req_tag;
  logic              mem_req_ready;
  logic              mem_rsp_valid;
  logic [CNT_W-1:0]  outstanding;
  logic              err_underflow;

  int n_vec = 0;
  int n_err = 0;

  bwd_mem_req_sched #(
    .ADDR_W(ADDR_W), .TAG_W(TAG_W), .MAX_OUTSTANDING(16), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_read_num(req_read_num),
    .req_addr_k(req_addr_k), .req_addr_l(req_addr_l), .stall(stall),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
    .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid),
    .outstanding(outstanding), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_port(input string tag, input logic v, input logic [63:0] a,
                          input logic [63:0] t, input logic s);
    chk({tag, ".valid"}, 64'(mem_req_valid), 64'(v));
    chk({tag, ".addr"},  64'(mem_req_addr),  a);
    chk({tag, ".tag"},   64'(mem_req_tag),   t);
    chk({tag, ".stall"}, 64'(stall),         64'(s));
  endtask

  task automatic present(input logic [TAG_W-1:0] rn, input logic [ADDR_W-1:0] k,
                         input logic [ADDR_W-1:0] l);
    req_valid    = 1'b1;
    req_read_num = rn;
    req_addr_k   = k;
    req_addr_l   = l;
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_read_num = '0; req_addr_k = '0; req_addr_l = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    step(); step();
    chk_port("reset", 1'b0, 64'h0, 64'h0, 1'b0);
    chk("reset.outstanding", 64'(outstanding), 64'd0);
    chk("reset.err", 64'(err_underflow), 64'd0);
    rst = 1'b1;
    step();
    chk_port("idle_no_req", 1'b0, 64'h0, 64'h0, 1'b0);

    // Single non-dup request: k then l, two handshakes.
    mem_req_ready = 1'b1;
    present(6'd5, 42'h100, 42'h180);
    step(); req_valid = 1'b0;
    chk_port("single.k", 1'b1, 64'h100, 64'h14, 1'b1);
    step();
    chk_port("single.l", 1'b1, 64'h180, 64'h16, 1'b1);
    chk("single.cnt1", 64'(outstanding), 64'd1);
    step();
    chk_port("single.done", 1'b0, 64'h0, 64'h0, 1'b0);
    chk("single.cnt2", 64'(outstanding), 64'd2);

    // Duplicate line: single request flagged dup.
    present(6'd3, 42'h240, 42'h240);
    step(); req_valid = 1'b0;
    chk_port("dup.k", 1'b1, 64'h240, 64'h0D, 1'b1);
    step();
    chk_port("dup.done", 1'b0, 64'h0, 64'h0, 1'b0);
    chk("dup.cnt", 64'(outstanding), 64'd3);

    // Backpressure during ISSUE_K for four cycles.
    mem_req_ready = 1'b0;
    present(6'd7, 42'h300, 42'h340);
    step(); req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_port("bp.hold", 1'b1, 64'h300, 64'h1C, 1'b1);
      if (i < 3) step();
    end
    mem_req_ready = 1'b1;
    step();
    chk_port("bp.l", 1'b1, 64'h340, 64'h1E, 1'b1);
    chk("bp.cnt", 64'(outstanding), 64'd4);

    // Handshake and response in the same cycle at outstanding=4.
    mem_rsp_valid = 1'b1;
    step();
    chk("simul.cnt", 64'(outstanding), 64'd4);
    chk("simul.valid", 64'(mem_req_valid), 64'd0);

    // Drain to zero, then one extra response underflows.
    for (int i = 0; i < 4; i++) step();
    chk("drain.cnt", 64'(outstanding), 64'd0);
    chk("drain.err", 64'(err_underflow), 64'd0);
    step();
    mem_rsp_valid = 1'b0;
    chk("uflow.cnt", 64'(outstanding), 64'd0);
    chk("uflow.err", 64'(err_underflow), 64'd1);

    // Seven non-dup requests with no responses: 14 in flight.
    for (int i = 0; i < 7; i++) begin
      present(6'(i), 42'h1000 + 42'(i * 128), 42'h1040 + 42'(i * 128));
      step(); req_valid = 1'b0;
      step(); step();
    end
    chk("credit.cnt14", 64'(outstanding), 64'd14);
    chk("credit.stall14", 64'(stall), 64'd0);
    present(6'd8, 42'h2000, 42'h2040);
    step(); req_valid = 1'b0;
    chk_port("credit.acc8", 1'b1, 64'h2000, 64'h20, 1'b1);
    step(); step();
    chk("credit.cnt16", 64'(outstanding), 64'd16);
    chk("credit.stall16", 64'(stall), 64'd1);
    present(6'd9, 42'h3000, 42'h3080);
    step();
    chk("credit.blocked16", 64'(mem_req_valid), 64'd0);
    mem_rsp_valid = 1'b1;
    step();
    chk("credit.cnt15", 64'(outstanding), 64'd15);
    chk_port("credit.blocked15", 1'b0, 64'h0, 64'h0, 1'b1);
    step();
    mem_rsp_valid = 1'b0;
    chk("credit.cnt14b", 64'(outstanding), 64'd14);
    chk_port("credit.open14", 1'b0, 64'h0, 64'h0, 1'b0);
    step(); req_valid = 1'b0;
    chk_port("credit.acc9", 1'b1, 64'h3000, 64'h24, 1'b1);
    step();
    chk_port("credit.l9", 1'b1, 64'h3080, 64'h26, 1'b1);
    chk("credit.cnt15b", 64'(outstanding), 64'd15);

    // Reset while holding the l request.
    rst = 1'b0;
    step();
    chk_port("rst_mid", 1'b0, 64'h0, 64'h0, 1'b0);
    chk("rst_mid.cnt", 64'(outstanding), 64'd0);
    chk("rst_mid.err", 64'(err_underflow), 64'd0);
    rst = 1'b1;
    step();
    chk_port("rst_mid.idle", 1'b0, 64'h0, 64'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
